iwht_4x4: RTL and testbench

- Inverse 4x4 Walsh-Hadamard transform.
- Accepts one block of 16 signed coefficients from the forward WHT path or dequantiser, and reconstructs 16 unsigned 8-bit pixels.
- Iterative datapath: one shared 4-point butterfly is time-multiplexed over 4 column passes, then 4 row passes.
- Valid/ready handshake on both sides; sits at the decoder/reconstruction end of the transform pipeline.

---
 rtl/wht_pkg.sv | 27 ++
 rtl/iwht_4x4_if.sv | 28 ++
 rtl/wht_bfly4.sv | 34 +++
 rtl/iwht_4x4.sv | 144 ++++++++++++++
 tb/tb_iwht_4x4.sv | 190 +++++++++++++++++++
 5 files changed

// File: rtl/wht_pkg.sv
// Shared constants and types for the 4x4 Walsh-Hadamard transform blocks.
// Latency: n/a (package only).
// Backpressure: n/a (package only).
//
// Contents: pixel/coefficient/intermediate widths, the FSM state encoding
// and the k = row*4 + col element index helper.
package wht_pkg;

  localparam int WIDTH0 = 8;   // output pixel width (unsigned)
  localparam int WIDTH2 = 13;  // input coefficient width (signed)
  localparam int WIDTH3 = 15;  // column-pass intermediate width (signed), >= WIDTH2+2

  localparam int NELEM = 16;   // elements per 4x4 block

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_COL  = 2'd1,
    ST_ROW  = 2'd2,
    ST_OUT  = 2'd3
  } state_t;

  // Element index k = row*4 + col; with 2-bit row/col this is just {row, col}.
  function automatic logic [3:0] idx(input logic [1:0] row, input logic [1:0] col);
    return {row, col};
  endfunction

endpackage

// File: rtl/iwht_4x4_if.sv
// Coefficient-in / pixel-out stream bundle for the inverse 4x4 WHT.
// Latency: n/a (wiring only).
// Backpressure: valid/ready on both streams; the producer holds data until ready.
//
// Signals: coef_i / coef_ivalid / coef_iready (block in, k = row*4+col),
//          pix_o / pix_ovalid / pix_oready (block out, same k ordering).
// Modports: slave = the transform block, master = the block's environment.
interface iwht_4x4_if;
  import wht_pkg::*;

  logic [NELEM*WIDTH2-1:0] coef_i;
  logic                    coef_ivalid;
  logic                    coef_iready;
  logic [NELEM*WIDTH0-1:0] pix_o;
  logic                    pix_ovalid;
  logic                    pix_oready;

  modport slave (
    input  coef_i, coef_ivalid, pix_oready,
    output coef_iready, pix_o, pix_ovalid
  );

  modport master (
    output coef_i, coef_ivalid, pix_oready,
    input  coef_iready, pix_o, pix_ovalid
  );

endinterface

// File: rtl/wht_bfly4.sv
// Combinational 4-point Walsh-Hadamard butterfly, shared by forward and inverse paths.
// Latency: 0 cycles (pure combinational).
// Backpressure: none; inputs map straight to outputs.
//
// Ports: a,b,c,d signed W-bit inputs; y0..y3 signed W+2-bit outputs
//   y0=(a+b)+(c+d), y1=(a-b)+(c-d), y2=(a+b)-(c+d), y3=(a-b)-(c-d).
module wht_bfly4 #(
  parameter int W = 15
) (
  input  logic signed [W-1:0] a,
  input  logic signed [W-1:0] b,
  input  logic signed [W-1:0] c,
  input  logic signed [W-1:0] d,
  output logic signed [W+1:0] y0,
  output logic signed [W+1:0] y1,
  output logic signed [W+1:0] y2,
  output logic signed [W+1:0] y3
);

  logic signed [W+1:0] s_ab, d_ab, s_cd, d_cd;

  always_comb begin
    // Everything is carried at W+2 bits so the 4-term sums never wrap.
    s_ab = {{2{a[W-1]}}, a} + {{2{b[W-1]}}, b};
    d_ab = {{2{a[W-1]}}, a} - {{2{b[W-1]}}, b};
    s_cd = {{2{c[W-1]}}, c} + {{2{d[W-1]}}, d};
    d_cd = {{2{c[W-1]}}, c} - {{2{d[W-1]}}, d};
    y0   = s_ab + s_cd;
    y1   = d_ab + d_cd;
    y2   = s_ab - s_cd;
    y3   = d_ab - d_cd;
  end

endmodule

// File: rtl/iwht_4x4.sv
// Inverse 4x4 WHT: 16 signed coefficients in, 16 clipped 8-bit pixels out, one shared butterfly.
// Latency: accept edge E0 -> pix_ovalid high after E8 (4 column + 4 row passes); min period 10 cycles.
// Backpressure: coef_iready only in IDLE; pix_o/pix_ovalid held in OUT until pix_oready.
//
// Ports: clk, rst (synchronous, active-high), io (iwht_4x4_if.slave: coef_* in, pix_* out).
// Build option: define IWHT_ROUND_EN for round-half-up scaling ((z+8)>>>4);
// otherwise the 1/16 scale truncates (z>>>4). Clipping to [0,255] is always present.
module iwht_4x4
  import wht_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  iwht_4x4_if.slave  io
);

  localparam int ZW = WIDTH3 + 2;  // row-pass result width
  localparam int TW = WIDTH3 + 3;  // one extra bit so the rounding add cannot overflow
  localparam logic signed [TW-1:0] PIX_MAX = TW'((1 << WIDTH0) - 1);

  state_t                    state_q, state_d;
  logic [1:0]                cnt_q, cnt_d;
  logic signed [WIDTH2-1:0]  coef_q [NELEM];
  logic signed [WIDTH2-1:0]  coef_d [NELEM];
  logic signed [WIDTH3-1:0]  mid_q  [NELEM];
  logic signed [WIDTH3-1:0]  mid_d  [NELEM];
  logic        [WIDTH0-1:0]  pix_q  [NELEM];
  logic        [WIDTH0-1:0]  pix_d  [NELEM];

  logic                      coef_rdy, pix_vld, coef_hs;
  logic signed [WIDTH3-1:0]  bf_in [4];
  logic signed [ZW-1:0]      bf_y  [4];
  logic [NELEM*WIDTH0-1:0]   pix_flat;

  // Divide by 16 (optionally rounded), then clip; out-of-range values saturate.
  function automatic logic [WIDTH0-1:0] scale_clip(input logic signed [ZW-1:0] z);
    logic signed [TW-1:0] t;
    logic signed [TW-1:0] s;
`ifdef IWHT_ROUND_EN
    t = $signed({z[ZW-1], z}) + TW'(8);
`else
    t = $signed({z[ZW-1], z});
`endif
    s = t >>> 4;
    if (s[TW-1])          return '0;
    else if (s > PIX_MAX) return '1;
    else                  return s[WIDTH0-1:0];
  endfunction

  // ---------------- FSM: state register ----------------
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      coef_q  <= '{default: '0};
      mid_q   <= '{default: '0};
      pix_q   <= '{default: '0};
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      coef_q  <= coef_d;
      mid_q   <= mid_d;
      pix_q   <= pix_d;
    end
  end

  // ---------------- FSM: next state ----------------
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    case (state_q)
      ST_IDLE: if (coef_hs) begin
        state_d = ST_COL;
        cnt_d   = '0;
      end
      ST_COL: begin
        cnt_d = cnt_q + 2'd1;
        if (cnt_q == 2'd3) state_d = ST_ROW;
      end
      ST_ROW: begin
        cnt_d = cnt_q + 2'd1;
        if (cnt_q == 2'd3) state_d = ST_OUT;
      end
      ST_OUT: if (io.pix_oready) state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  // ---------------- FSM: outputs ----------------
  always_comb begin
    // Gated by rst so the block never advertises ready while being reset.
    coef_rdy = (state_q == ST_IDLE) && !rst;
    pix_vld  = (state_q == ST_OUT);
    coef_hs  = io.coef_ivalid && coef_rdy;
  end

  assign io.coef_iready = coef_rdy;
  assign io.pix_ovalid  = pix_vld;

  // ---------------- Datapath ----------------
  // Butterfly operand mux: column cnt of coef_buf (sign-extended) or row cnt of mid_buf.
  always_comb begin
    for (int j = 0; j < 4; j++) begin
      if (state_q == ST_ROW) begin
        bf_in[j] = mid_q[idx(cnt_q, 2'(j))];
      end else begin
        bf_in[j] = {{(WIDTH3-WIDTH2){coef_q[idx(2'(j), cnt_q)][WIDTH2-1]}},
                    coef_q[idx(2'(j), cnt_q)]};
      end
    end
  end

  wht_bfly4 #(.W(WIDTH3)) u_bfly (
    .a  (bf_in[0]),
    .b  (bf_in[1]),
    .c  (bf_in[2]),
    .d  (bf_in[3]),
    .y0 (bf_y[0]),
    .y1 (bf_y[1]),
    .y2 (bf_y[2]),
    .y3 (bf_y[3])
  );

  always_comb begin
    coef_d = coef_q;
    mid_d  = mid_q;
    pix_d  = pix_q;
    case (state_q)
      ST_IDLE: if (coef_hs) begin
        for (int k = 0; k < NELEM; k++) coef_d[k] = io.coef_i[k*WIDTH2 +: WIDTH2];
      end
      // Column outputs fit in WIDTH2+2 <= WIDTH3 bits, so dropping the top bits is lossless.
      ST_COL: for (int j = 0; j < 4; j++) mid_d[idx(2'(j), cnt_q)] = bf_y[j][WIDTH3-1:0];
      ST_ROW: for (int j = 0; j < 4; j++) pix_d[idx(cnt_q, 2'(j))] = scale_clip(bf_y[j]);
      default: ;
    endcase
  end

  always_comb begin
    for (int k = 0; k < NELEM; k++) pix_flat[k*WIDTH0 +: WIDTH0] = pix_q[k];
  end

  assign io.pix_o = pix_flat;

endmodule

// File: tb/tb_iwht_4x4.sv
// Directed self-checking bench for iwht_4x4: DC, two-tone pattern, saturation,
// rounding/truncation, output backpressure with a queued block, and reset mid-row-pass.
module tb_iwht_4x4;
  import wht_pkg::*;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   n_assert = 0;
  int   n_fail   = 0;

  iwht_4x4_if io ();

  iwht_4x4 dut (
    .clk (clk),
    .rst (rst),
    .io  (io)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    n_assert++;
    assert (obs === exp)
    else begin
      n_fail++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic logic [127:0] fill(input logic [7:0] v);
    return {16{v}};
  endfunction

  function automatic logic [NELEM*WIDTH2-1:0] mk(input int k0, input int k1);
    logic [NELEM*WIDTH2-1:0] v;
    v = '0;
    v[0 +: WIDTH2]      = WIDTH2'(k0);
    v[WIDTH2 +: WIDTH2] = WIDTH2'(k1);
    return v;
  endfunction

  // Present a block and return just after its accepting edge (E0).
  task automatic send_block(input logic [NELEM*WIDTH2-1:0] c);
    int guard;
    @(negedge clk);
    io.coef_i      = c;
    io.coef_ivalid = 1'b1;
    guard = 0;
    while (!io.coef_iready && guard < 40) begin
      @(negedge clk);
      guard++;
    end
    if (guard >= 40) check("accept_timeout", 128'd1, 128'd0);
    @(posedge clk);
    #1 io.coef_ivalid = 1'b0;
  endtask

  // Count edges after E0 until pix_ovalid is seen high (bounded).
  task automatic wait_out(output int lat);
    lat = 0;
    do begin
      @(posedge clk);
      lat++;
      #1;
    end while (!io.pix_ovalid && lat < 40);
  endtask

  task automatic release_out(input string tag);
    @(negedge clk);
    io.pix_oready = 1'b1;
    @(posedge clk);
    #1 io.pix_oready = 1'b0;
    check(tag, 128'(io.pix_ovalid), 128'd0);
  endtask

  logic [127:0] pat_exp;
  logic [127:0] rnd_exp;

  initial begin
    int lat;
    int hi;
    io.coef_i      = '0;
    io.coef_ivalid = 1'b0;
    io.pix_oready  = 1'b0;
    // Row word, col3..col0: columns 0,2 = 110 and columns 1,3 = 90.
    pat_exp = {4{8'd90, 8'd110, 8'd90, 8'd110}};
`ifdef IWHT_ROUND_EN
    rnd_exp = fill(8'd1);
`else
    rnd_exp = fill(8'd0);
`endif

    // ---- reset state ----
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_iready", 128'(io.coef_iready), 128'd0);
    check("rst_ovalid", 128'(io.pix_ovalid), 128'd0);
    check("rst_pix", io.pix_o, 128'd0);
    rst = 1'b0;
    #1 check("post_rst_iready", 128'(io.coef_iready), 128'd1);

    // ---- DC block ----
    send_block(mk(2048, 0));
    wait_out(lat);
    check("dc_latency", 128'(lat), 128'd8);
    check("dc_pix", io.pix_o, fill(8'd128));
    release_out("dc_drop");
    check("dc_idle_iready", 128'(io.coef_iready), 128'd1);
    check("dc_pix_retained", io.pix_o, fill(8'd128));

    // ---- two-tone pattern ----
    send_block(mk(1600, 160));
    wait_out(lat);
    check("pat_latency", 128'(lat), 128'd8);
    check("pat_pix", io.pix_o, pat_exp);
    release_out("pat_drop");

    // ---- saturation high / low ----
    send_block(mk(4095, 0));
    wait_out(lat);
    check("sat_hi_latency", 128'(lat), 128'd8);
    check("sat_hi_pix", io.pix_o, fill(8'd255));
    release_out("sat_hi_drop");

    send_block(mk(-160, 0));
    wait_out(lat);
    check("sat_lo_latency", 128'(lat), 128'd8);
    check("sat_lo_pix", io.pix_o, fill(8'd0));
    release_out("sat_lo_drop");

    // ---- rounding vs truncation ----
    send_block(mk(8, 0));
    wait_out(lat);
    check("rnd_pix", io.pix_o, rnd_exp);
    release_out("rnd_drop");

    // ---- backpressure with a second block queued ----
    send_block(mk(1600, 160));
    wait_out(lat);
    check("bp_latency", 128'(lat), 128'd8);
    @(negedge clk);
    io.coef_i      = mk(2048, 0);
    io.coef_ivalid = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      check("bp_ovalid", 128'(io.pix_ovalid), 128'd1);
      check("bp_pix_stable", io.pix_o, pat_exp);
      check("bp_iready", 128'(io.coef_iready), 128'd0);
    end
    io.pix_oready = 1'b1;
    @(posedge clk);
    #1 io.pix_oready = 1'b0;
    check("bp_drop", 128'(io.pix_ovalid), 128'd0);
    check("bp_iready_after_hs", 128'(io.coef_iready), 128'd1);
    @(posedge clk);
    #1 io.coef_ivalid = 1'b0;
    check("bp_second_taken", 128'(io.coef_iready), 128'd0);
    wait_out(lat);
    check("bp2_latency", 128'(lat), 128'd8);
    check("bp2_pix", io.pix_o, fill(8'd128));
    release_out("bp2_drop");

    // ---- reset during ROW pass (cnt=2 after E6) ----
    send_block(mk(1600, 160));
    repeat (6) @(posedge clk);
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    #1;
    check("mrst_ovalid", 128'(io.pix_ovalid), 128'd0);
    check("mrst_iready", 128'(io.coef_iready), 128'd1);
    check("mrst_pix", io.pix_o, 128'd0);
    hi = 0;
    repeat (12) begin
      @(negedge clk);
      if (io.pix_ovalid) hi++;
    end
    check("mrst_no_output", 128'(hi), 128'd0);
    send_block(mk(2048, 0));
    wait_out(lat);
    check("mrst_dc_latency", 128'(lat), 128'd8);
    check("mrst_dc_pix", io.pix_o, fill(8'd128));
    release_out("mrst_dc_drop");

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
